// File: rtl/seq_div12.sv
// Unsigned restoring shift-subtract divider: one quotient bit per clock, MSB first.
// Divide-by-zero finishes in one clock with an all-ones quotient and the dividend as remainder.
module seq_div12 #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   part;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic [WIDTH:0]   part_next;
  logic [WIDTH-1:0] dq_next;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    shifted   = {part, dq[WIDTH-1]};
    trial     = shifted - {2'b00, dvs};
    q_bit     = ~trial[WIDTH+1];
    part_next = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    dq_next   = {dq[WIDTH-2:0], q_bit};
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dq        <= '0;
      dvs       <= '0;
      part      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              div0      <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              div0  <= 1'b0;
              dq    <= dividend;
              dvs   <= divisor;
              part  <= '0;
              cnt   <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          part <= part_next;
          dq   <= dq_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= dq_next;
            remainder <= part_next[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div12.sv
// Self-checking bench for seq_div12: directed cases, start/reset corner cases and a random
// regression, with expected results queued at stimulus time and popped on done.
module tb_seq_div12;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] dividend;
  logic [11:0] divisor;
  logic        busy;
  logic        done;
  logic [11:0] quotient;
  logic [11:0] remainder;
  logic        div0;

  typedef struct {
    logic [11:0] q;
    logic [11:0] r;
    logic        d0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_div12 #(.WIDTH(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pick();
    case ($urandom_range(0, 7))
      0:       return 12'd0;
      1:       return 12'hFFF;
      2:       return 12'($urandom_range(1, 15));
      default: return 12'($urandom);
    endcase
  endfunction

  // Called at a negedge; start is sampled by the next posedge. glitch>0 re-pulses start
  // with other operands in that cycle of the run.
  task automatic run_op(input logic [11:0] a, input logic [11:0] b, input int glitch);
    exp_t e;
    exp_t got;
    int   cyc;
    int   busy_n;
    int   done_cyc;
    e.q   = (b == 0) ? 12'hFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.d0  = (b == 0);
    e.lat = (b == 0) ? 1 : 13;
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    dividend = 12'($urandom);
    divisor  = 12'($urandom);
    cyc      = 1;
    busy_n   = 0;
    done_cyc = 0;
    while (cyc <= 40) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy) busy_n++;
      start = (cyc == glitch);
      if (cyc == glitch) begin
        dividend = 12'd200;
        divisor  = 12'd3;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    got   = sb.pop_front();
    check("done_latency", done_cyc, got.lat);
    check("busy_cycles", busy_n, got.lat - 1);
    check("busy_with_done", 32'(busy), 0);
    check("quotient", 32'(quotient), 32'(got.q));
    check("remainder", 32'(remainder), 32'(got.r));
    check("div0", 32'(div0), 32'(got.d0));
  endtask

  initial begin
    logic [11:0] a;
    logic [11:0] b;
    int          late_done;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_quotient", 32'(quotient), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_div0", 32'(div0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(12'd100, 12'd7, 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("hold_quotient", 32'(quotient), 14);
    check("hold_remainder", 32'(remainder), 2);
    run_op(12'd4095, 12'd1, 0);
    @(negedge clk);
    run_op(12'd5, 12'd9, 0);
    @(negedge clk);
    run_op(12'd123, 12'd0, 0);
    run_op(12'd100, 12'd7, 0);

    // Start re-pulsed mid-run is ignored, then a back-to-back start from DONE.
    @(negedge clk);
    run_op(12'd100, 12'd7, 5);
    run_op(12'd4000, 12'd13, 0);

    // Asynchronous reset in cycle 6 of a run.
    @(negedge clk);
    start    = 1'b1;
    dividend = 12'd100;
    divisor  = 12'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_done", 32'(done), 0);
    check("midrun_rst_quotient", 32'(quotient), 0);
    check("midrun_rst_remainder", 32'(remainder), 0);
    check("midrun_rst_div0", 32'(div0), 0);
    @(negedge clk);
    rst       = 1'b0;
    late_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    check("no_done_after_rst", late_done, 0);
    run_op(12'd4095, 12'd4095, 0);

    for (int i = 0; i < 1500; i++) begin
      a = pick();
      b = pick();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
      run_op(a, b, 0);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
